react_timer: RTL and testbench
==============================

// Module: react_timer
// PURPOSE
//  Timing front-end for the reaction tester, upstream of the game state machine.
//  It generates the random pre-stimulus delay and the 1 ms reaction counter.
//  It also synchronises the player button.
//  It consumes the machine state and drives signal_start, signal_react,
//  signal_overflow, signal_cleared and react_time.
// PARAMETERS
//  TICK_DIV     12000  clk cycles per 1 ms tick (12 MHz clock)
//  MAX_TIME     999    react counter saturation value, in ms
//  DELAY_MIN_MS 1000   minimum pre-stimulus delay, in ms
//  DELAY_MASK   1023   mask applied to the LFSR for the random delay part, in ms
// PORTS
//  clk             in   1   system clock
//  rst             in   1   asynchronous reset, active-high
//  machine_state   in   3   0 IDLE, 1 WAIT, 2 CLR_CNT1, 3 START, 4 STORAGE,
//                           5 CLR_CNT2, 6 AVERAGE, 7 COMPARE
//  btn             in   1   player button, active-high, debounced, asynchronous to clk
//  signal_start    out  1   pre-stimulus delay elapsed (level)
//  signal_react    out  1   valid press captured in START (level)
//  signal_overflow out  1   no press before MAX_TIME (level)
//  signal_cleared  out  1   counters cleared (level)
//  react_time      out  10  captured reaction time, in ms
// BEHAVIOUR
//  - Reset: all outputs 0. Prescaler = 0, delay counter = 0, LFSR = 16'hACE1.
//  - Reset mid-operation: everything returns to the reset values immediately.
//  - Button: 2-FF synchroniser, then a rising-edge detector.
//    A press is a single-cycle pulse, 3 clk after the btn edge.
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11. It steps every clk, except in reset.
//  - Prescaler: counts 0..TICK_DIV-1 in WAIT and START only.
//    The tick pulse occurs when it wraps to 0. It is held at 0 in all other states.
//  - State change detection: prev_state register.
//    "Entry" = machine_state != prev_state.
//  - WAIT:
//    - On entry: delay_cnt <= DELAY_MIN_MS + (lfsr & DELAY_MASK), signal_start <= 0.
//    - Each tick with delay_cnt != 0: decrement delay_cnt.
//    - When delay_cnt == 0: signal_start <= 1 the next clk, held until WAIT is left.
//    - Presses in WAIT are ignored.
//  - CLR_CNT1 / CLR_CNT2:
//    - Cycle 1 (entry): react counter, prescaler, react, overflow and start flags <= 0.
//    - signal_cleared <= 1 on the clk after entry, held while in the state.
//    - It drops 1 clk after the state is left.
//  - START:
//    - The counter increments on each tick while below MAX_TIME.
//    - On the first press: react_time <= counter (frozen), signal_react <= 1.
//    - When the counter reaches MAX_TIME with no press: signal_overflow <= 1,
//      react_time <= MAX_TIME.
//    - Flags are held until the state changes. Further presses are ignored.
//    - A press in the same clk as reaching MAX_TIME: press wins,
//      react_time = MAX_TIME, signal_react = 1, signal_overflow = 0.
//    - A button already held on START entry does not count. It needs a release
//      and a new rising edge.
//  - STORAGE, AVERAGE, COMPARE, IDLE:
//    - react_time holds its last value.
//    - signal_react, signal_overflow and signal_start <= 0 on entry.
//  - Widths: react counter 10 bits (MAX_TIME <= 1023), delay_cnt 12 bits,
//    prescaler 14 bits.
//  - All outputs are registered. No combinational path from input to output.
// CONFIGURATION
//  RANDOM_DELAY_EN defined:   delay = DELAY_MIN_MS + (lfsr & DELAY_MASK), as above.
//  RANDOM_DELAY_EN undefined: the LFSR is removed. Delay = DELAY_MIN_MS on every
//                             WAIT entry (deterministic benches).
// TESTING
//  Bench uses TICK_DIV = 4, MAX_TIME = 20, DELAY_MIN_MS = 5, DELAY_MASK = 3,
//  RANDOM_DELAY_EN undefined.
//  1. Reset with rst = 1 mid-WAIT -> all outputs 0 within the same clk.
//     After release, IDLE leaves the outputs at 0.
//  2. WAIT for 30 clk -> signal_start rises 21 clk after WAIT entry
//     (5 ticks × 4 + 1) and stays 1.
//  3. CLR_CNT1, then START; btn rises after 7 ticks ->
//     react_time = 7 and signal_react = 1, 3 clk after the edge.
//     signal_overflow stays 0.
//  4. START with no press -> signal_overflow = 1 and react_time = 20 after
//     20 ticks. signal_react stays 0.
//  5. btn held high across START entry -> no signal_react.
//     Release and re-press at tick 3 -> react_time = 3.
//  6. CLR_CNT2 entry after test 3 -> signal_cleared = 1 the next clk,
//     react and overflow flags = 0. signal_cleared falls 1 clk after the state
//     goes to WAIT.

Source files
------------

// File: rtl/react_timer.sv
// react_timer: reaction-tester timing front-end (tick prescaler, random pre-stimulus delay, 1 ms reaction counter, button sync).
// Define RANDOM_DELAY_EN to add the LFSR random part to the WAIT delay; otherwise the delay is fixed at DELAY_MIN_MS.
module react_timer #(
    parameter int TICK_DIV     = 12000,
    parameter int MAX_TIME     = 999,
    parameter int DELAY_MIN_MS = 1000,
    parameter int DELAY_MASK   = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] machine_state,
    input  logic       btn,
    output logic       signal_start,
    output logic       signal_react,
    output logic       signal_overflow,
    output logic       signal_cleared,
    output logic [9:0] react_time
);
    localparam logic [2:0]  S_WAIT = 3'd1, S_CLR1 = 3'd2, S_START = 3'd3, S_CLR2 = 3'd5;
    localparam logic [13:0] TICK_LAST = 14'(TICK_DIV - 1);
    localparam logic [9:0]  MAXT = 10'(MAX_TIME);
    localparam logic [11:0] DMIN = 12'(DELAY_MIN_MS);
    logic [2:0]  prev_state;
    logic [2:0]  btn_sync;
    logic [13:0] presc;
    logic [11:0] delay_cnt;
    logic [11:0] delay_load;
    logic [9:0]  cnt;
    logic        entry, in_wait, in_start, in_clr, counting, tick, press, done;
    assign entry    = machine_state != prev_state;
    assign in_wait  = machine_state == S_WAIT;
    assign in_start = machine_state == S_START;
    assign in_clr   = machine_state == S_CLR1 || machine_state == S_CLR2;
    assign counting = in_wait || in_start;
    assign tick     = counting && presc == TICK_LAST;
    assign press    = btn_sync[1] && !btn_sync[2];
    assign done     = signal_react || signal_overflow;
`ifdef RANDOM_DELAY_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or posedge rst)
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign delay_load = DMIN + 12'(lfsr & 16'(DELAY_MASK));
`else
    assign delay_load = DMIN;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state <= '0;
            btn_sync   <= '0;
            presc      <= '0;
            delay_cnt  <= '0;
            cnt        <= '0;
        end else begin
            prev_state <= machine_state;
            btn_sync   <= {btn_sync[1:0], btn};
            presc      <= (counting && !tick) ? presc + 14'd1 : 14'd0;
            if (in_wait && entry) delay_cnt <= delay_load;
            else if (in_wait && tick && delay_cnt != 12'd0) delay_cnt <= delay_cnt - 12'd1;
            if (in_clr && entry) cnt <= '0;
            else if (in_start && tick && cnt < MAXT) cnt <= cnt + 10'd1;
        end
    end
    // A press landing on the cycle the counter sits at MAX_TIME beats the overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signal_start    <= 1'b0;
            signal_react    <= 1'b0;
            signal_overflow <= 1'b0;
            signal_cleared  <= 1'b0;
            react_time      <= '0;
        end else begin
            signal_cleared <= in_clr && !entry;
            signal_start   <= in_wait ? (!entry && (signal_start || delay_cnt == 12'd0))
                                      : (signal_start && !entry);
            if (in_start) begin
                if (!done && press) begin
                    react_time   <= cnt;
                    signal_react <= 1'b1;
                end else if (!done && cnt == MAXT) begin
                    react_time      <= MAXT;
                    signal_overflow <= 1'b1;
                end
            end else if (entry && !in_wait) begin
                signal_react    <= 1'b0;
                signal_overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_react_timer.sv
// tb_react_timer: directed checks of react_timer with small bench parameters and a fixed delay.
module tb_react_timer;
    localparam logic [2:0] IDLE = 3'd0, WAIT = 3'd1, CLR1 = 3'd2, START = 3'd3,
                           STORAGE = 3'd4, CLR2 = 3'd5;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ms = IDLE;
    logic       btn = 1'b0;
    logic       signal_start, signal_react, signal_overflow, signal_cleared;
    logic [9:0] react_time;
    int vectors = 0;
    int fails = 0;
    react_timer #(.TICK_DIV(4), .MAX_TIME(20), .DELAY_MIN_MS(5), .DELAY_MASK(3)) dut (
        .clk(clk), .rst(rst), .machine_state(ms), .btn(btn),
        .signal_start(signal_start), .signal_react(signal_react),
        .signal_overflow(signal_overflow), .signal_cleared(signal_cleared),
        .react_time(react_time)
    );
    always #5 clk = ~clk;
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 32'(signal_start), 0);
        chk({tag, "_react"}, 32'(signal_react), 0);
        chk({tag, "_ovf"}, 32'(signal_overflow), 0);
        chk({tag, "_clr"}, 32'(signal_cleared), 0);
        chk({tag, "_time"}, 32'(react_time), 0);
    endtask
    initial begin
        step(3);
        rst = 1'b0;
        chk_all_zero("reset");
        step(2);
        chk_all_zero("idle");
        ms = WAIT;
        step(20);
        chk("wait20_start", 32'(signal_start), 0);
        step(1);
        chk("wait21_start", 32'(signal_start), 1);
        step(9);
        chk("wait30_start", 32'(signal_start), 1);
        ms = CLR1;
        step(1);
        chk("clr1_entry_start", 32'(signal_start), 0);
        chk("clr1_entry_cleared", 32'(signal_cleared), 0);
        step(1);
        chk("clr1_cleared", 32'(signal_cleared), 1);
        step(1);
        ms = START;
        step(28);
        chk("t3_pre_react", 32'(signal_react), 0);
        btn = 1'b1;
        step(2);
        chk("t3_sync_react", 32'(signal_react), 0);
        step(1);
        chk("t3_react", 32'(signal_react), 1);
        chk("t3_time", 32'(react_time), 7);
        chk("t3_ovf", 32'(signal_overflow), 0);
        btn = 1'b0;
        step(60);
        chk("t3_hold_time", 32'(react_time), 7);
        chk("t3_hold_ovf", 32'(signal_overflow), 0);
        chk("t3_hold_react", 32'(signal_react), 1);
        ms = CLR2;
        step(1);
        chk("t6_react", 32'(signal_react), 0);
        chk("t6_ovf", 32'(signal_overflow), 0);
        chk("t6_entry_cleared", 32'(signal_cleared), 0);
        chk("t6_time_held", 32'(react_time), 7);
        step(1);
        chk("t6_cleared", 32'(signal_cleared), 1);
        ms = WAIT;
        step(1);
        chk("t6_cleared_drop", 32'(signal_cleared), 0);
        step(2);
        ms = CLR1;
        step(2);
        ms = START;
        step(80);
        chk("t4_pre_ovf", 32'(signal_overflow), 0);
        step(1);
        chk("t4_ovf", 32'(signal_overflow), 1);
        chk("t4_time", 32'(react_time), 20);
        chk("t4_react", 32'(signal_react), 0);
        ms = STORAGE;
        step(1);
        chk("storage_ovf", 32'(signal_overflow), 0);
        chk("storage_time", 32'(react_time), 20);
        ms = CLR1;
        step(1);
        btn = 1'b1;
        step(4);
        ms = START;
        step(4);
        chk("t5_held_react", 32'(signal_react), 0);
        btn = 1'b0;
        step(8);
        chk("t5_released_react", 32'(signal_react), 0);
        btn = 1'b1;
        step(2);
        chk("t5_sync_react", 32'(signal_react), 0);
        step(1);
        chk("t5_react", 32'(signal_react), 1);
        chk("t5_time", 32'(react_time), 3);
        ms = WAIT;
        step(25);
        chk("t1_pre_start", 32'(signal_start), 1);
        chk("t1_pre_react", 32'(signal_react), 1);
        #3 rst = 1'b1;
        #1;
        chk_all_zero("t1_async");
        step(1);
        rst = 1'b0;
        ms = IDLE;
        step(3);
        chk_all_zero("t1_idle");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
